bidir_cnt: RTL and testbench

BIDIR_CNT -- requirements
Module: bidir_cnt

---
 rtl/bidir_cnt_if.sv | 37 +++
 rtl/bidir_cnt.sv | 101 ++++++++++
 tb/tb_bidir_cnt.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bidir_cnt_if.sv
// Bundle of control inputs and status outputs for bidir_cnt.
//   master : drives i_en, i_dir, i_sat (and i_load, i_load_val); observes o_*
//   slave  : the counter; observes i_*, drives o_cnt, o_wrap, o_hit,
//            o_at_max, o_at_min
// Optional load signals exist only when BIDIR_CNT_LOAD_EN is defined.
interface bidir_cnt_if #(
  parameter int W = 4
);
`ifdef BIDIR_CNT_LOAD_EN
  logic         i_load;
  logic [W-1:0] i_load_val;
`endif
  logic         i_en;
  logic         i_dir;
  logic         i_sat;
  logic [W-1:0] o_cnt;
  logic         o_wrap;
  logic         o_hit;
  logic         o_at_max;
  logic         o_at_min;

  modport master (
`ifdef BIDIR_CNT_LOAD_EN
    output i_load, i_load_val,
`endif
    output i_en, i_dir, i_sat,
    input  o_cnt, o_wrap, o_hit, o_at_max, o_at_min
  );

  modport slave (
`ifdef BIDIR_CNT_LOAD_EN
    input  i_load, i_load_val,
`endif
    input  i_en, i_dir, i_sat,
    output o_cnt, o_wrap, o_hit, o_at_max, o_at_min
  );
endinterface

// File: rtl/bidir_cnt.sv
// Bidirectional bounded counter over [LOBND, UPBND], wrap or saturate at bounds.
// Ports:
//   i_clk  : clock, all state changes on the rising edge
//   i_rst  : synchronous active-high reset (count -> LOBND)
//   bus    : bidir_cnt_if slave (i_en, i_dir, i_sat, [i_load, i_load_val],
//            o_cnt, o_wrap, o_hit, o_at_max, o_at_min), all outputs registered
// Macro BIDIR_CNT_LOAD_EN enables the parallel load (clamped to the bounds).
// Priority per cycle: reset > load > enable > hold.
module bidir_cnt #(
  parameter int UPBND = 15,
  parameter int LOBND = 0
) (
  input logic      i_clk,
  input logic      i_rst,
  bidir_cnt_if.slave bus
);
  localparam int W = $clog2(UPBND + 1);

  localparam logic [W:0]   UP_X = (W+1)'(UPBND);
  localparam logic [W:0]   LO_X = (W+1)'(LOBND);
  localparam logic [W-1:0] UP_W = W'(UPBND);
  localparam logic [W-1:0] LO_W = W'(LOBND);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic         hit_q, hit_d;
  logic         at_max_q, at_min_q;
  logic [W:0]   cnt_x;
  logic [W:0]   step_x;
  logic         load;
  logic [W:0]   load_x;

`ifdef BIDIR_CNT_LOAD_EN
  assign load   = bus.i_load;
  assign load_x = {1'b0, bus.i_load_val};
`else
  assign load   = 1'b0;
  assign load_x = '0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    hit_d  = 1'b0;
    cnt_x  = {1'b0, cnt_q};
    step_x = cnt_x;
    if (load) begin
      if (load_x < LO_X)      cnt_d = LO_W;
      else if (load_x > UP_X) cnt_d = UP_W;
      else                    cnt_d = W'(load_x);
    end else if (bus.i_en) begin
      if (bus.i_dir) begin
        // Bound test happens before the step so the W+1 sum never leaves range.
        if (cnt_x >= UP_X) begin
          if (bus.i_sat) hit_d = 1'b1;
          else begin
            cnt_d  = LO_W;
            wrap_d = 1'b1;
          end
        end else begin
          step_x = cnt_x + 1'b1;
          cnt_d  = W'(step_x);
        end
      end else begin
        if (cnt_x <= LO_X) begin
          if (bus.i_sat) hit_d = 1'b1;
          else begin
            cnt_d  = UP_W;
            wrap_d = 1'b1;
          end
        end else begin
          step_x = cnt_x - 1'b1;
          cnt_d  = W'(step_x);
        end
      end
    end
  end

  // Bound flags derive from cnt_d so they align with the new count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= LO_W;
      wrap_q   <= 1'b0;
      hit_q    <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      hit_q    <= hit_d;
      at_max_q <= (cnt_d == UP_W);
      at_min_q <= (cnt_d == LO_W);
    end
  end

  assign bus.o_cnt    = cnt_q;
  assign bus.o_wrap   = wrap_q;
  assign bus.o_hit    = hit_q;
  assign bus.o_at_max = at_max_q;
  assign bus.o_at_min = at_min_q;
endmodule

// File: tb/tb_bidir_cnt.sv
// Directed bench for bidir_cnt: default-bound instance A and LOBND=3/UPBND=9
// instance B, driven from one clock. Load checks exist only with
// BIDIR_CNT_LOAD_EN defined.
module tb_bidir_cnt;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  bidir_cnt_if #(.W(4)) bus_a ();
  bidir_cnt_if #(.W(4)) bus_b ();

  bidir_cnt #(.UPBND(15), .LOBND(0)) u_a (.i_clk(clk), .i_rst(rst_a), .bus(bus_a));
  bidir_cnt #(.UPBND(9),  .LOBND(3)) u_b (.i_clk(clk), .i_rst(rst_b), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input int w, input int h);
    chk({tag, ".cnt"},  32'(bus_a.o_cnt), 32'(c));
    chk({tag, ".wrap"}, 32'(bus_a.o_wrap), 32'(w));
    chk({tag, ".hit"},  32'(bus_a.o_hit), 32'(h));
    chk({tag, ".max"},  32'(bus_a.o_at_max), 32'(c == 15));
    chk({tag, ".min"},  32'(bus_a.o_at_min), 32'(c == 0));
  endtask

  task automatic chk_b(input string tag, input int c, input int w, input int h);
    chk({tag, ".cnt"},  32'(bus_b.o_cnt), 32'(c));
    chk({tag, ".wrap"}, 32'(bus_b.o_wrap), 32'(w));
    chk({tag, ".hit"},  32'(bus_b.o_hit), 32'(h));
    chk({tag, ".max"},  32'(bus_b.o_at_max), 32'(c == 9));
    chk({tag, ".min"},  32'(bus_b.o_at_min), 32'(c == 3));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_en = 1'b0; bus_a.i_dir = 1'b1; bus_a.i_sat = 1'b0;
    bus_b.i_en = 1'b0; bus_b.i_dir = 1'b1; bus_b.i_sat = 1'b0;
`ifdef BIDIR_CNT_LOAD_EN
    bus_a.i_load = 1'b0; bus_a.i_load_val = '0;
    bus_b.i_load = 1'b0; bus_b.i_load_val = '0;
`endif
    step();
    chk_a("rst_a", 0, 0, 0);
    chk_b("rst_b", 3, 0, 0);

    // Up-count with wrap: 1..15, 0, 1
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.i_en = 1'b1; bus_a.i_dir = 1'b1; bus_a.i_sat = 1'b0;
    for (int unsigned i = 1; i <= 17; i++) begin
      step();
      chk_a($sformatf("up%0d", i), int'(i % 16), int'(i == 16), 0);
    end

    // Down from reset wraps to top, then 14, 13
    rst_a = 1'b1;
    step();
    rst_a = 1'b0; bus_a.i_dir = 1'b0;
    step(); chk_a("dn_wrap", 15, 1, 0);
    step(); chk_a("dn14", 14, 0, 0);
    step(); chk_a("dn13", 13, 0, 0);
    for (int unsigned i = 0; i < 6; i++) step();
    chk_a("dn7", 7, 0, 0);

    // Direction toggle every cycle, no dead cycle
    bus_a.i_dir = 1'b1; step(); chk_a("tog1", 8, 0, 0);
    bus_a.i_dir = 1'b0; step(); chk_a("tog2", 7, 0, 0);
    bus_a.i_dir = 1'b1; step(); chk_a("tog3", 8, 0, 0);
    bus_a.i_dir = 1'b0; step(); chk_a("tog4", 7, 0, 0);

    // Disabled: hold
    bus_a.i_en = 1'b0; bus_a.i_dir = 1'b1;
    step(); chk_a("hold1", 7, 0, 0);
    step(); chk_a("hold2", 7, 0, 0);

    // Count to 11, then reset overrides enable (and load)
    bus_a.i_en = 1'b1;
    for (int unsigned i = 0; i < 4; i++) step();
    chk_a("to11", 11, 0, 0);
    rst_a = 1'b1;
`ifdef BIDIR_CNT_LOAD_EN
    bus_a.i_load = 1'b1; bus_a.i_load_val = 4'd5;
`endif
    step(); chk_a("rst_mid", 0, 0, 0);
    rst_a = 1'b0;
`ifdef BIDIR_CNT_LOAD_EN
    bus_a.i_load = 1'b0;
`endif
    step(); chk_a("resume", 1, 0, 0);
    bus_a.i_en = 1'b0;

    // Instance B: saturate up 4..9 then hold 9 with hit
    bus_b.i_en = 1'b1; bus_b.i_dir = 1'b1; bus_b.i_sat = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      step();
      chk_b($sformatf("satup%0d", i), (i <= 6) ? int'(3 + i) : 9, 0, int'(i > 6));
    end
    bus_b.i_dir = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) step();
    chk_b("satdn3", 3, 0, 0);
    step(); chk_b("satdn_hold", 3, 0, 1);
    step(); chk_b("satdn_hold2", 3, 0, 1);
    // Same bound in wrap mode jumps to UPBND
    bus_b.i_sat = 1'b0;
    step(); chk_b("b_wrap", 9, 1, 0);
    bus_b.i_dir = 1'b1;
    step(); chk_b("b_wrap_up", 3, 1, 0);
    bus_b.i_en = 1'b0;
    step(); chk_b("b_idle", 3, 0, 0);

`ifdef BIDIR_CNT_LOAD_EN
    // Load wins over enable, value not stepped
    bus_a.i_en = 1'b1; bus_a.i_dir = 1'b1; bus_a.i_load = 1'b1; bus_a.i_load_val = 4'd12;
    step(); chk_a("ld12", 12, 0, 0);
    bus_a.i_load = 1'b0;
    step(); chk_a("ld12_next", 13, 0, 0);
    bus_a.i_en = 1'b0;
    bus_b.i_load = 1'b1; bus_b.i_load_val = 4'd1;
    step(); chk_b("ld_lo_clamp", 3, 0, 0);
    bus_b.i_load_val = 4'd15;
    step(); chk_b("ld_hi_clamp", 9, 0, 0);
    bus_b.i_load_val = 4'd6;
    step(); chk_b("ld6", 6, 0, 0);
    bus_b.i_load = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
